load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
//
// PURPOSE
//   Initiator side of the data-memory interface. Accepts one load/store at a time
//   from the CPU using the 3-bit MemOp encoding, and serialises it into little-endian
//   byte transactions on a byte-wide memory port with a req/ack handshake.
//   Sign- or zero-extends load data and returns it with a one-cycle response pulse.
//   Sits between the execute stage and the data-memory responder.
//
// PARAMETERS
//   ADDR_W          32   address width, CPU side and memory side
//   TIMEOUT_CYCLES  16   cycles m_req may wait without m_ack before abort; 0 = never abort
//
// PORTS
//   clk         in   1       clock, all state updates on posedge
//   rst_n       in   1       asynchronous active-low reset
//   req_valid   in   1       CPU request valid
//   req_ready   out  1       LSU can accept a request (high only in IDLE)
//   req_we      in   1       1 = store, 0 = load
//   req_op      in   3       MemOp: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned
//   req_addr    in   ADDR_W  byte address
//   req_wdata   in   32      store data; low bytes used for byte/half
//   resp_valid  out  1       one-cycle completion pulse
//   resp_rdata  out  32      extended load data; 0 for stores and errors
//   resp_err    out  1       illegal op, misalignment (optional) or timeout; valid with resp_valid
//   m_req       out  1       memory byte request
//   m_we        out  1       memory byte write enable
//   m_addr      out  ADDR_W  memory byte address
//   m_wdata     out  8       memory write byte
//   m_ack       in   1       memory accepted/completed the current byte this cycle
//   m_rdata     in   8       read byte; valid in the cycle m_ack is high on a read
//
// BEHAVIOUR
//   - Reset (async): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, m_req=0, m_we=0,
//     m_addr=0, m_wdata=0; req_ready=1 once reset is released. Reset mid-op abandons the
//     transfer and drops m_req immediately. No response is issued for the abandoned op.
//   - States: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP for rejected requests.
//   - IDLE: on req_valid && req_ready, latch we/op/addr/wdata, set byte count N to 4, 1 or 2,
//     and set idx=0. Illegal op (011/100/111), or a store with 101/110, goes straight to RESP
//     with err=1 and no bus activity.
//   - ACCESS: m_req=1, m_we=we, m_addr=addr+idx (wraps mod 2^ADDR_W), m_wdata=wdata[8*idx+:8].
//     On m_ack: a load stores m_rdata into byte lane idx. If idx==N-1, go to RESP; otherwise
//     idx++ and m_req stays high with the next address (back-to-back bytes allowed).
//   - Timeout: a counter runs while m_req is high and clears on each m_ack. When it reaches
//     TIMEOUT_CYCLES, go to RESP with err=1 and drop m_req.
//   - RESP: resp_valid=1 for exactly one cycle, then IDLE. rdata is extended per op:
//     001/010 sign-extend from bit 7/15; 101/110 zero-extend; 000 passes the word.
//   - Latency with m_ack tied high: accept at edge 0, RESP at edge N+1.
//   - req_valid while busy is ignored (req_ready low). Request fields are not re-sampled.
//
// CONFIGURATION
//   MISALIGN_CHECK_EN defined: a half access with addr[0]!=0 or a word access with
//     addr[1:0]!=0 is rejected at accept (IDLE->RESP, err=1, no m_req).
//   Not defined: misaligned accesses proceed byte-serially and complete normally.
//
// STRUCTURE
//   lsu_pkg: MemOp localparams (OP_W, OP_B, OP_H, OP_BU, OP_HU), state encoding,
//     and function op_nbytes(op).
//   Sub-module lsu_extend: combinational sign/zero extension of the assembled word by op.
//
// TESTING
//   1. ack=1, load op=000 @0x10, mem bytes 78 56 34 12 -> m_addr 10,11,12,13; rdata=0x12345678 on cycle 5.
//   2. load op=001 @0x20 byte 0x80 -> rdata=0xFFFFFF80; op=101 same -> 0x00000080.
//   3. store op=010 @0x30 wdata=0xAABBCCDD, ack delayed 2 cycles per byte -> writes DD@30, CC@31; err=0.
//   4. op=011 -> resp_valid next cycle, err=1, m_req never asserts; with MISALIGN_CHECK_EN,
//      word @0x02 -> err=1 (without it: 4 byte accesses 02..05).
//   5. m_ack held 0 -> after 16 cycles resp err=1, m_req drops; rst_n low mid-ACCESS -> m_req=0 at once, no resp.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings, FSM state
// encoding and the per-op byte count.
package lsu_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b101;
  localparam logic [2:0] OP_HU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Number of bytes moved for an op; 0 flags an illegal encoding.
  function automatic logic [2:0] op_nbytes(input logic [2:0] op);
    case (op)
      OP_W:         op_nbytes = 3'd4;
      OP_B, OP_BU:  op_nbytes = 3'd1;
      OP_H, OP_HU:  op_nbytes = 3'd2;
      default:      op_nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled little-endian load word by MemOp.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  // Select the extension implied by the op; words pass through untouched.
  always_comb begin
    ext = word;
    case (op)
      OP_B:    ext = {{24{word[7]}}, word[7:0]};
      OP_H:    ext = {{16{word[15]}}, word[15:0]};
      OP_BU:   ext = {24'h000000, word[7:0]};
      OP_HU:   ext = {16'h0000, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serialises one CPU load/store into little-endian byte
// transactions on a req/ack byte port, with timeout abort and extension of
// load data. Optional build macro MISALIGN_CHECK_EN rejects misaligned
// half/word accesses at accept time.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready for a request; latches fields on req_valid
//   ST_ACCESS | m_req high, one byte per m_ack, timeout counter running
//   ST_RESP   | single-cycle resp_valid pulse, then back to idle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic              m_ack,
  input  logic [7:0]        m_rdata
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES);

  state_t            state, nstate;
  logic              we_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;
  logic [1:0]        idx_q;
  logic [31:0]       rbuf_q;
  logic              err_q;
  logic [TW-1:0]     tmr_q;

  logic [2:0]        nb;
  logic              reject;
  logic              misalign;
  logic              last_byte;
  logic              timeout_hit;
  logic [31:0]       ext_word;

  assign nb     = op_nbytes(req_op);
  // Stores have no notion of unsigned; op[2] set on a store is illegal.
  assign reject = (nb == 3'd0) || (req_we && req_op[2]);

`ifdef MISALIGN_CHECK_EN
  assign misalign = ((nb == 3'd2) && req_addr[0]) ||
                    ((nb == 3'd4) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign last_byte   = (idx_q == last_q);
  // Down-counter terminal count; an ack in the same cycle always wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !m_ack && (tmr_q == TW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // Next-state decode.
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) nstate = (reject || misalign) ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_ack && last_byte) nstate = ST_RESP;
        else if (timeout_hit)   nstate = ST_RESP;
      end
      ST_RESP: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // Request capture, byte sequencing, load assembly and timeout timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      op_q    <= OP_W;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            last_q  <= nb[1:0] - 2'd1;
            idx_q   <= '0;
            rbuf_q  <= '0;
            err_q   <= reject || misalign;
            tmr_q   <= T_LOAD;
          end
        end
        ST_ACCESS: begin
          if (m_ack) begin
            if (!we_q) rbuf_q[{idx_q, 3'b000} +: 8] <= m_rdata;
            idx_q <= idx_q + 2'd1;
            tmr_q <= T_LOAD;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  lsu_extend u_extend (
    .op   (op_q),
    .word (rbuf_q),
    .ext  (ext_word)
  );

  assign req_ready  = (state == ST_IDLE);
  assign m_req      = (state == ST_ACCESS);
  assign m_we       = m_req && we_q;
  assign m_addr     = m_req ? (addr_q + ADDR_W'(idx_q)) : '0;
  assign m_wdata    = m_we ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus hand sequences
// for ack delay, busy requests, timeout and mid-access reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TO     = 16;

`ifdef MISALIGN_CHECK_EN
  localparam bit MA = 1'b1;
`else
  localparam bit MA = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic              m_ack;
  logic [7:0]        m_rdata;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Byte memory model and responder state.
  logic [7:0] mem [256];
  int         ack_delay = 0;
  bit         ack_hold  = 1'b0;
  int         wcnt      = 0;
  logic [31:0] log_addr[$];
  logic [7:0]  log_wdata[$];
  bit          log_we[$];

  // Responder: decides m_ack on the falling edge, handshake on the next rise.
  initial begin
    m_ack   = 1'b0;
    m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (m_req && !ack_hold && rst_n) begin
        if (wcnt >= ack_delay) begin
          m_ack   = 1'b1;
          m_rdata = m_we ? 8'h00 : mem[m_addr[7:0]];
          log_addr.push_back(m_addr);
          log_we.push_back(m_we);
          log_wdata.push_back(m_wdata);
          if (m_we) mem[m_addr[7:0]] = m_wdata;
          wcnt = 0;
        end else begin
          m_ack = 1'b0;
          wcnt++;
        end
      end else begin
        m_ack = 1'b0;
        if (!m_req) wcnt = 0;
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_n;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                              input int n);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.exp_n = n; v.exp_lat = n;
    return v;
  endfunction

  // Misaligned access: rejected outright with the check, byte-serial without.
  function automatic vec_t mk_ma(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rd, input int n);
    if (MA) return mk(we, op, addr, wdata, 32'h0, 1'b1, 0);
    return mk(we, op, addr, wdata, rd, 1'b0, n);
  endfunction

  task automatic run_req(input string name, input vec_t v);
    int g, edges, mreq_cycles, nlog;
    bit seen;
    exp_t e;
    logic [31:0] wd;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~v.we; req_op = 3'b111; req_addr = ~v.addr; req_wdata = ~v.wdata;
    edges = 0; mreq_cycles = 0; seen = 1'b0;
    while (!seen && edges < 200) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({name, "_rdata"}, resp_rdata, e.rdata);
          chk({name, "_err"}, 32'(resp_err), 32'(e.err));
        end
        chk({name, "_mreq_in_resp"}, 32'(m_req), 32'd0);
      end else begin
        if (m_req) mreq_cycles++;
        @(posedge clk);
        edges++;
      end
    end
    chk({name, "_resp_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(edges), 32'(v.exp_lat));
    chk({name, "_mreq_cycles"}, 32'(mreq_cycles), 32'(v.exp_lat));
    @(negedge clk);
    chk({name, "_pulse_len"}, 32'(resp_valid), 32'd0);
    nlog = log_addr.size();
    chk({name, "_nbytes"}, 32'(nlog), 32'(v.exp_n));
    wd = v.wdata;
    for (int i = 0; i < nlog && i < 4; i++) begin
      chk($sformatf("%s_addr%0d", name, i), log_addr[i], 32'(v.addr + 32'(i)));
      chk($sformatf("%s_we%0d", name, i), 32'(log_we[i]), 32'(v.we));
      if (v.we) chk($sformatf("%s_wdata%0d", name, i), 32'(log_wdata[i]), 32'(wd[8*i +: 8]));
    end
  endtask

  vec_t vecs[19];
  vec_t hv;
  int   rcount;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
    mem[8'h03] = 8'h44; mem[8'h04] = 8'h55; mem[8'h05] = 8'h66;
    mem[8'hFF] = 8'hAA;
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
    mem[8'h20] = 8'h80; mem[8'h40] = 8'h34; mem[8'h41] = 8'h92; mem[8'h50] = 8'h7F;

    vecs[0]  = mk(1'b0, OP_W,   32'h10, 32'h0, 32'h12345678, 1'b0, 4);
    vecs[1]  = mk(1'b0, OP_B,   32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    vecs[2]  = mk(1'b0, OP_BU,  32'h20, 32'h0, 32'h00000080, 1'b0, 1);
    vecs[3]  = mk(1'b0, OP_H,   32'h40, 32'h0, 32'hFFFF9234, 1'b0, 2);
    vecs[4]  = mk(1'b0, OP_HU,  32'h40, 32'h0, 32'h00009234, 1'b0, 2);
    vecs[5]  = mk(1'b0, OP_B,   32'h50, 32'h0, 32'h0000007F, 1'b0, 1);
    vecs[6]  = mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    vecs[7]  = mk(1'b0, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    vecs[8]  = mk(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    vecs[9]  = mk(1'b1, OP_BU,  32'h70, 32'h55, 32'h0, 1'b1, 0);
    vecs[10] = mk(1'b1, OP_HU,  32'h70, 32'h55, 32'h0, 1'b1, 0);
    vecs[11] = mk(1'b1, OP_W,   32'h60, 32'hCAFEF00D, 32'h0, 1'b0, 4);
    vecs[12] = mk(1'b0, OP_W,   32'h60, 32'h0, 32'hCAFEF00D, 1'b0, 4);
    vecs[13] = mk(1'b1, OP_B,   32'h70, 32'h123456A5, 32'h0, 1'b0, 1);
    vecs[14] = mk(1'b0, OP_BU,  32'h70, 32'h0, 32'h000000A5, 1'b0, 1);
    vecs[15] = mk_ma(1'b0, OP_W, 32'h02, 32'h0, 32'h66554433, 4);
    vecs[16] = mk_ma(1'b0, OP_W, 32'hFFFFFFFF, 32'h0, 32'h332211AA, 4);
    vecs[17] = mk_ma(1'b0, OP_H, 32'h41, 32'h0, 32'h00000092, 2);
    vecs[18] = mk_ma(1'b1, OP_H, 32'h03, 32'h0000BEEF, 32'h0, 2);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = OP_W;
    req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", 32'(m_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 19; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Store half with two wait cycles per byte.
    ack_delay = 2;
    hv = mk(1'b1, OP_H, 32'h30, 32'hAABBCCDD, 32'h0, 1'b0, 2);
    hv.exp_lat = 6;
    run_req("slow_store", hv);
    ack_delay = 0;
    run_req("slow_store_rb", mk(1'b0, OP_HU, 32'h30, 32'h0, 32'h0000CCDD, 1'b0, 2));

    // New request presented while busy must be ignored.
    ack_delay = 3;
    hv = mk(1'b0, OP_W, 32'h10, 32'h0, 32'h12345678, 1'b0, 4);
    hv.exp_lat = 16;
    fork
      run_req("busy", hv);
      begin
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = OP_B; req_addr = 32'h20; req_wdata = 32'hEE;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk($sformatf("busy_ready%0d", k), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
      end
    join
    ack_delay = 0;
    rcount = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) rcount++; end
    chk("busy_no_extra_resp", 32'(rcount), 32'd0);
    chk("busy_mem_untouched", 32'(mem[8'h20]), 32'h80);

    // No ack at all: abort after the timeout.
    ack_hold = 1'b1;
    hv = mk(1'b0, OP_W, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    hv.exp_lat = TO;
    run_req("timeout", hv);
    ack_hold = 1'b0;
    run_req("after_timeout", mk(1'b0, OP_B, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 1));

    // Reset in the middle of an access.
    ack_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = OP_W; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_mreq_before", 32'(m_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mreq_now", 32'(m_req), 32'd0);
    chk("midrst_m_addr", m_addr, 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ack_hold = 1'b0;
    rcount = 0;
    repeat (20) begin @(negedge clk); if (resp_valid || m_req) rcount++; end
    chk("midrst_no_resp", 32'(rcount), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
